// File: rtl/lfsr_sched_if.sv
// Client, engine and status signals of the LFSR cipher-session scheduler.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface lfsr_sched_if #(
  parameter int unsigned LEN_W = 4
);
  logic             reqA, reqB;
  logic [7:0]       keyA, keyB;
  logic [2:0]       tapA, tapB;
  logic [LEN_W-1:0] lenA, lenB;
  logic [7:0]       dataA, dataB;
  logic             validA, validB;
  logic             readyA, readyB;
  logic             grantA, grantB;
  logic [7:0]       resA, resB;
  logic             res_validA, res_validB;
  logic             doneA, doneB;
  logic [7:0]       eng_key;
  logic [2:0]       eng_tap;
  logic             eng_start, eng_stop;
  logic [7:0]       eng_in_byte;
  logic             eng_in_en;
  logic [7:0]       eng_out_byte;
  logic             eng_out_en;
  logic             busy;

  modport slave (
    input  reqA, reqB, keyA, keyB, tapA, tapB, lenA, lenB,
           dataA, dataB, validA, validB, eng_out_byte, eng_out_en,
    output readyA, readyB, grantA, grantB, resA, resB, res_validA, res_validB,
           doneA, doneB, eng_key, eng_tap, eng_start, eng_stop,
           eng_in_byte, eng_in_en, busy
  );

  modport master (
    output reqA, reqB, keyA, keyB, tapA, tapB, lenA, lenB,
           dataA, dataB, validA, validB, eng_out_byte, eng_out_en,
    input  readyA, readyB, grantA, grantB, resA, resB, res_validA, res_validB,
           doneA, doneB, eng_key, eng_tap, eng_start, eng_stop,
           eng_in_byte, eng_in_en, busy
  );
endinterface

// File: rtl/lfsr_sched.sv
// Two-client round-robin scheduler that owns one LFSR cipher engine per session:
// loads key/tap, streams the owner's bytes in, routes results back, signals completion.
module lfsr_sched #(
  parameter int unsigned START_CYC = 2,
  parameter int unsigned LEN_W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  lfsr_sched_if.slave  bus
);
  localparam int unsigned      SC_W    = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(START_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;   // 0 = A, 1 = B
  logic             last_q, last_d;     // most recently granted client
  logic [7:0]       key_q, key_d;
  logic [2:0]       tap_q, tap_d;
  logic [LEN_W:0]   len_q, len_d;
  logic [LEN_W:0]   sent_q, sent_d;
  logic [LEN_W:0]   rcvd_q, rcvd_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [7:0]       in_byte_q, in_byte_d;
  logic             in_en_q, in_en_d;

  logic       any_req, win, in_session, owner_req, owner_valid;
  logic [7:0] owner_data;
  logic       ready, accept, res_hit;
  logic       gnt_a, gnt_b, start, stop, done_a, done_b;

  assign any_req     = bus.reqA | bus.reqB;
  assign win         = (bus.reqA && bus.reqB) ? ~last_q : bus.reqB;
  assign in_session  = (state_q == LOAD) || (state_q == STREAM) || (state_q == DRAIN);
  assign owner_req   = owner_q ? bus.reqB   : bus.reqA;
  assign owner_valid = owner_q ? bus.validB : bus.validA;
  assign owner_data  = owner_q ? bus.dataB  : bus.dataA;
  assign ready       = (state_q == STREAM) && owner_req && (sent_q < len_q);
  assign accept      = ready && owner_valid;
  // A dropped request silences results in the same cycle the stop is issued.
  assign res_hit     = in_session && owner_req && bus.eng_out_en;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    key_d     = key_q;
    tap_d     = tap_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sent_d    = sent_q + (LEN_W+1)'(accept);
    rcvd_d    = rcvd_q + (LEN_W+1)'(res_hit);
    in_en_d   = accept;
    in_byte_d = accept ? owner_data : '0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grant is shown in the arbitration cycle itself, forced low while reset is held.
        gnt_a = reset && any_req && !win;
        gnt_b = reset && any_req && win;
        if (any_req) begin
          owner_d = win;
          last_d  = win;
          key_d   = win ? bus.keyB : bus.keyA;
          tap_d   = win ? bus.tapB : bus.tapA;
          len_d   = win ? {(bus.lenB == '0), bus.lenB} : {(bus.lenA == '0), bus.lenA};
          sent_d  = '0;
          rcvd_d  = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          stop    = 1'b1;
          state_d = IDLE;
        end else begin
          gnt_a = !owner_q;
          gnt_b = owner_q;
          start = 1'b1;
          cnt_d = cnt_q + SC_W'(1);
          if (cnt_q == SC_LAST) begin
            cnt_d   = '0;
            state_d = STREAM;
          end
        end
      end
      STREAM, DRAIN: begin
        if (!owner_req) begin
          stop    = 1'b1;
          state_d = IDLE;
        end else begin
          gnt_a = !owner_q;
          gnt_b = owner_q;
          if (rcvd_d == len_q)
            state_d = DONE;
          else if ((state_q == STREAM) && (sent_d == len_q))
            state_d = DRAIN;
        end
      end
      DONE: begin
        done_a  = !owner_q;
        done_b  = owner_q;
        stop    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      key_q     <= '0;
      tap_q     <= '0;
      len_q     <= '0;
      sent_q    <= '0;
      rcvd_q    <= '0;
      cnt_q     <= '0;
      in_byte_q <= '0;
      in_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      key_q     <= key_d;
      tap_q     <= tap_d;
      len_q     <= len_d;
      sent_q    <= sent_d;
      rcvd_q    <= rcvd_d;
      cnt_q     <= cnt_d;
      in_byte_q <= in_byte_d;
      in_en_q   <= in_en_d;
    end
  end

  assign bus.readyA      = ready && !owner_q;
  assign bus.readyB      = ready && owner_q;
  assign bus.grantA      = gnt_a;
  assign bus.grantB      = gnt_b;
  assign bus.res_validA  = res_hit && !owner_q;
  assign bus.res_validB  = res_hit && owner_q;
  assign bus.resA        = (res_hit && !owner_q) ? bus.eng_out_byte : '0;
  assign bus.resB        = (res_hit && owner_q)  ? bus.eng_out_byte : '0;
  assign bus.doneA       = done_a;
  assign bus.doneB       = done_b;
  assign bus.eng_key     = start ? key_q : '0;
  assign bus.eng_tap     = start ? tap_q : '0;
  assign bus.eng_start   = start;
  assign bus.eng_stop    = stop;
  assign bus.eng_in_byte = in_byte_q;
  assign bus.eng_in_en   = in_en_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched: a stub engine returns byte^5A; accepted bytes are
// queued as expected engine inputs and client results and checked when they emerge.
module tb_lfsr_sched;
  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_sched_if #(.LEN_W(LEN_W)) bus ();

  lfsr_sched #(.START_CYC(2), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.eng_out_en   = bus.eng_in_en;
  assign bus.eng_out_byte = bus.eng_in_byte ^ 8'h5A;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] qIn[$];
  logic [7:0] qA[$];
  logic [7:0] qB[$];
  int start_cnt = 0, in_cnt = 0, resA_cnt = 0, resB_cnt = 0;
  int doneA_cnt = 0, doneB_cnt = 0, stop_cnt = 0, gB_cnt = 0;
  logic       prev_acc = 1'b0, prev_rst = 1'b0;
  logic [7:0] exp_key = '0;
  logic [2:0] exp_tap = '0;

  always @(negedge clk) begin
    logic acc_a, acc_b;
    check("eng_in_en_timing", bus.eng_in_en, prev_acc && prev_rst);
    if (bus.eng_in_en) begin
      in_cnt++;
      check("eng_in_pending", qIn.size() > 0, 1);
      if (qIn.size() > 0) check("eng_in_byte", bus.eng_in_byte, qIn.pop_front());
    end
    if (bus.res_validA) begin
      resA_cnt++;
      check("resA_pending", qA.size() > 0, 1);
      if (qA.size() > 0) check("resA", bus.resA, qA.pop_front());
    end
    if (bus.res_validB) begin
      resB_cnt++;
      check("resB_pending", qB.size() > 0, 1);
      if (qB.size() > 0) check("resB", bus.resB, qB.pop_front());
    end
    check("grant_onehot", bus.grantA && bus.grantB, 0);
    check("ready_owner", (bus.readyA && !bus.grantA) || (bus.readyB && !bus.grantB), 0);
    if (bus.eng_start) begin
      start_cnt++;
      check("eng_key", bus.eng_key, exp_key);
      check("eng_tap", bus.eng_tap, exp_tap);
    end
    if (bus.doneA) doneA_cnt++;
    if (bus.doneB) doneB_cnt++;
    if (bus.eng_stop) stop_cnt++;
    if (bus.grantB) gB_cnt++;
    acc_a = bus.readyA && bus.validA;
    acc_b = bus.readyB && bus.validB;
    if (acc_a) begin qIn.push_back(bus.dataA); qA.push_back(bus.dataA ^ 8'h5A); end
    if (acc_b) begin qIn.push_back(bus.dataB); qB.push_back(bus.dataB ^ 8'h5A); end
    prev_acc = acc_a || acc_b;
    prev_rst = reset;
  end

  int b_start, b_in, b_resA, b_resB, b_doneA, b_doneB, b_stop, b_gB;

  task automatic snap();
    b_start = start_cnt; b_in = in_cnt; b_resA = resA_cnt; b_resB = resB_cnt;
    b_doneA = doneA_cnt; b_doneB = doneB_cnt; b_stop = stop_cnt; b_gB = gB_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cli, input logic v, input logic [7:0] d);
    if (cli) begin bus.validB = v; bus.dataB = d; end
    else     begin bus.validA = v; bus.dataA = d; end
  endtask

  task automatic stream(input bit cli, input int n, input logic [7:0] first, input bit toggle);
    int   i = 0;
    int   guard = 0;
    logic v = 1'b1;
    logic acc;
    drive(cli, v, first);
    while (i < n && guard < 200) begin
      @(negedge clk);
      acc = cli ? (bus.readyB && bus.validB) : (bus.readyA && bus.validA);
      tick();
      guard++;
      if (acc) i++;
      if (toggle) v = ~v;
      drive(cli, v, first + 8'(i));
    end
    drive(cli, 1'b0, first + 8'(i));
    check("stream_accepted", i, n);
  endtask

  task automatic wait_done(input bit cli, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = cli ? bus.doneB : bus.doneA;
    end
    check(cli ? "doneB_wait" : "doneA_wait", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.reqA = 0; bus.reqB = 0; bus.keyA = '0; bus.keyB = '0;
    bus.tapA = '0; bus.tapB = '0; bus.lenA = '0; bus.lenB = '0;
    bus.dataA = '0; bus.dataB = '0; bus.validA = 0; bus.validB = 0;
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {bus.busy, bus.grantA, bus.grantB, bus.readyA, bus.readyB,
                       bus.res_validA, bus.res_validB, bus.doneA, bus.doneB,
                       bus.eng_start, bus.eng_stop, bus.eng_in_en}, 0);
    check("rst_data", {bus.eng_key, bus.eng_tap, bus.eng_in_byte}, 0);
    check("rst_res", {bus.resA, bus.resB}, 0);
    tick();
    reset = 1'b1;

    // Single A session, len 8
    exp_key = 8'h95; exp_tap = 3'd4;
    bus.reqA = 1; bus.keyA = 8'h95; bus.tapA = 3'd4; bus.lenA = 4'd8;
    snap();
    @(negedge clk);
    check("t1_grantA", bus.grantA, 1);
    check("t1_busy_idle", bus.busy, 0);
    tick();
    stream(0, 8, 8'h61, 0);
    wait_done(0, 40);
    tick(); bus.reqA = 0;
    tick();
    check("t1_starts", start_cnt - b_start, 2);
    check("t1_in", in_cnt - b_in, 8);
    check("t1_resA", resA_cnt - b_resA, 8);
    check("t1_doneA", doneA_cnt - b_doneA, 1);
    check("t1_grantB", gB_cnt - b_gB, 0);
    check("t1_stop", stop_cnt - b_stop, 1);
    check("t1_busy", bus.busy, 0);

    // Simultaneous requests after reset: A first, then B
    reset = 1'b0; tick(); reset = 1'b1;
    bus.reqA = 1; bus.keyA = 8'h11; bus.tapA = 3'd1; bus.lenA = 4'd2;
    bus.reqB = 1; bus.keyB = 8'h22; bus.tapB = 3'd2; bus.lenB = 4'd2;
    exp_key = 8'h11; exp_tap = 3'd1;
    snap();
    @(negedge clk);
    check("t2_A_first", {bus.grantA, bus.grantB}, 2'b10);
    tick();
    stream(0, 2, 8'h10, 0);
    wait_done(0, 40);
    tick();
    exp_key = 8'h22; exp_tap = 3'd2;
    @(negedge clk);
    check("t2_B_after_doneA", {bus.grantA, bus.grantB}, 2'b01);
    tick();
    stream(1, 2, 8'h20, 0);
    wait_done(1, 40);
    tick(); bus.reqA = 0; bus.reqB = 0;
    tick();
    check("t2_doneA", doneA_cnt - b_doneA, 1);
    check("t2_doneB", doneB_cnt - b_doneB, 1);
    check("t2_res", (resA_cnt - b_resA) * 16 + (resB_cnt - b_resB), 8'h22);
    check("t2_starts", start_cnt - b_start, 4);

    // A aborts after 3 bytes while B waits; B then runs len=0 (16 bytes)
    bus.reqA = 1; bus.keyA = 8'h33; bus.tapA = 3'd3; bus.lenA = 4'd8;
    bus.reqB = 1; bus.keyB = 8'h44; bus.tapB = 3'd5; bus.lenB = 4'd0;
    exp_key = 8'h33; exp_tap = 3'd3;
    snap();
    @(negedge clk);
    check("t3_A_wins", {bus.grantA, bus.grantB}, 2'b10);
    tick();
    stream(0, 3, 8'h30, 0);
    tick(); bus.reqA = 0;
    exp_key = 8'h44; exp_tap = 3'd5;
    @(negedge clk);
    check("t3_stop", bus.eng_stop, 1);
    check("t3_resA_quiet", bus.res_validA, 0);
    tick();
    @(negedge clk);
    check("t3_grantB", bus.grantB, 1);
    tick();
    @(negedge clk);
    check("t3_B_load", {bus.busy, bus.eng_start}, 2'b11);
    check("t3_stop_once", stop_cnt - b_stop, 1);
    check("t3_no_doneA", doneA_cnt - b_doneA, 0);
    check("t3_resA", resA_cnt - b_resA, 3);
    check("t3_qA_empty", qA.size(), 0);
    snap();
    tick();
    stream(1, 16, 8'h80, 0);
    @(negedge clk);
    check("t3_readyB_after16", bus.readyB, 0);
    wait_done(1, 40);
    tick(); bus.reqB = 0;
    tick();
    check("t3_in16", in_cnt - b_in, 16);
    check("t3_resB16", resB_cnt - b_resB, 16);
    check("t3_doneB", doneB_cnt - b_doneB, 1);

    // Toggling valid, len 4
    bus.reqA = 1; bus.keyA = 8'h55; bus.tapA = 3'd6; bus.lenA = 4'd4;
    exp_key = 8'h55; exp_tap = 3'd6;
    snap();
    tick();
    stream(0, 4, 8'hA0, 1);
    wait_done(0, 40);
    check("t4_resA_at_done", resA_cnt - b_resA, 4);
    tick(); bus.reqA = 0;
    tick();
    check("t4_in", in_cnt - b_in, 4);
    check("t4_doneA", doneA_cnt - b_doneA, 1);

    // Reset during STREAM, then a fresh B session
    bus.reqB = 1; bus.keyB = 8'h66; bus.tapB = 3'd7; bus.lenB = 4'd8;
    exp_key = 8'h66; exp_tap = 3'd7;
    snap();
    tick();
    stream(1, 3, 8'hC0, 0);
    tick(); reset = 1'b0;
    tick();
    @(negedge clk);
    check("t5_rst_ctrl", {bus.busy, bus.grantA, bus.grantB, bus.readyA, bus.readyB,
                          bus.res_validA, bus.res_validB, bus.doneA, bus.doneB,
                          bus.eng_start, bus.eng_stop, bus.eng_in_en}, 0);
    check("t5_rst_data", {bus.eng_key, bus.eng_tap, bus.eng_in_byte}, 0);
    check("t5_no_doneB", doneB_cnt - b_doneB, 0);
    check("t5_qB_empty", qB.size(), 0);
    tick(); reset = 1'b1;
    @(negedge clk);
    check("t5_grantB", bus.grantB, 1);
    snap();
    tick();
    stream(1, 8, 8'hD0, 0);
    wait_done(1, 40);
    tick(); bus.reqB = 0;
    tick();
    check("t5_resB", resB_cnt - b_resB, 8);
    check("t5_doneB", doneB_cnt - b_doneB, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
